// File: rtl/qed_dup_scheduler.sv
// -----------------------------------------------------------------------------
// qed_dup_scheduler
//
// Purpose:
//   Sits between a constrained symbolic instruction source and the core fetch
//   port and sequences original/duplicate issue for self-consistency checking.
//   Originals (using x0-x15) are passed to the core and recorded in a FIFO.
//   When exec_dup is raised, or the FIFO fills, the FIFO is replayed as
//   duplicates whose register fields are moved into x16-x31. qed_ready marks
//   the point where every original has a matching duplicate.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   ena             global enable; low freezes all state and outputs
//   exec_dup        request to enter the duplicate phase
//   ifu_instr/valid instruction from the symbolic source
//   ifu_ready       source handshake (transfer when ifu_valid && ifu_ready)
//   core_ready      core accepts instr_out this cycle
//   instr_out/vld   registered instruction to the core; is_dup tags duplicates
//   qed_ready       registered check-point flag
//   orig_cnt        originals issued since reset (saturating)
//   dup_cnt         duplicates issued since reset (saturating)
//   q_full/q_empty  FIFO occupancy flags
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The output slot is free when it is empty or the core takes it
// this cycle; while instr_vld && !core_ready the output holds unchanged.
//
// Build option:
//   QED_MEM_REMAP_EN  when defined, duplicate loads/stores also get
//                     instr[30] set so original and duplicate memory traffic
//                     lands in disjoint halves. Undefined: register remap only.
// -----------------------------------------------------------------------------
module qed_dup_scheduler #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             exec_dup,
    input  logic [31:0]      ifu_instr,
    input  logic             ifu_valid,
    output logic             ifu_ready,
    input  logic             core_ready,
    output logic [31:0]      instr_out,
    output logic             instr_vld,
    output logic             is_dup,
    output logic             qed_ready,
    output logic [CNT_W-1:0] orig_cnt,
    output logic [CNT_W-1:0] dup_cnt,
    output logic             q_full,
    output logic             q_empty
);

    typedef enum logic {
        ST_ORIG = 1'b0,
        ST_DUP  = 1'b1
    } state_t;

    localparam logic [6:0]       OPC_OP    = 7'b0110011;
    localparam logic [6:0]       OPC_OPIMM = 7'b0010011;
    localparam logic [6:0]       OPC_LOAD  = 7'b0000011;
    localparam logic [6:0]       OPC_STORE = 7'b0100011;
    localparam logic [6:0]       OPC_NOP   = 7'b1111111;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [AW:0]      OCC_FULL  = (AW+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic [31:0]      instr_out_q, instr_out_d;
    logic             instr_vld_q, instr_vld_d;
    logic             is_dup_q, is_dup_d;
    logic             qed_ready_q, qed_ready_d;
    logic [CNT_W-1:0] orig_cnt_q, orig_cnt_d;
    logic [CNT_W-1:0] dup_cnt_q, dup_cnt_d;
    logic             sat_q, sat_d;

    logic             slot_free;
    logic             full_w;
    logic             push;
    logic             pop;

    // Move a nonzero register number into the upper bank; x0 stays x0 so
    // hardwired-zero semantics are preserved in the duplicate.
    function automatic logic [4:0] remap_reg(input logic [4:0] r);
        return (r == 5'd0) ? 5'd0 : {1'b1, r[3:0]};
    endfunction

    function automatic logic [31:0] dup_remap(input logic [31:0] i);
        logic [31:0] r;
        r = i;
        case (i[6:0])
            OPC_OP: begin
                r[11:7]  = remap_reg(i[11:7]);
                r[19:15] = remap_reg(i[19:15]);
                r[24:20] = remap_reg(i[24:20]);
            end
            OPC_OPIMM: begin
                r[11:7]  = remap_reg(i[11:7]);
                r[19:15] = remap_reg(i[19:15]);
            end
            OPC_LOAD: begin
                r[11:7]  = remap_reg(i[11:7]);
                r[19:15] = remap_reg(i[19:15]);
`ifdef QED_MEM_REMAP_EN
                r[30]    = 1'b1;
`endif
            end
            OPC_STORE: begin
                r[19:15] = remap_reg(i[19:15]);
                r[24:20] = remap_reg(i[24:20]);
`ifdef QED_MEM_REMAP_EN
                r[30]    = 1'b1;
`endif
            end
            default: r = i;
        endcase
        return r;
    endfunction

    assign slot_free = !instr_vld_q || core_ready;
    assign full_w    = (occ_q == OCC_FULL);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        mem_d       = mem_q;
        instr_out_d = instr_out_q;
        instr_vld_d = instr_vld_q;
        is_dup_d    = is_dup_q;
        qed_ready_d = qed_ready_q;
        orig_cnt_d  = orig_cnt_q;
        dup_cnt_d   = dup_cnt_q;
        sat_d       = sat_q;
        ifu_ready   = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;

        if (ena) begin
            case (state_q)
                ST_ORIG: begin
                    ifu_ready = slot_free && !full_w;
                    if (ifu_valid && ifu_ready) begin
                        instr_out_d = ifu_instr;
                        instr_vld_d = 1'b1;
                        is_dup_d    = 1'b0;
                        // NOPs reach the core but have no duplicate.
                        push        = (ifu_instr[6:0] != OPC_NOP);
                    end else if (slot_free) begin
                        instr_vld_d = 1'b0;
                    end
                    // A push in the same cycle lands first; replay starts next cycle.
                    if ((exec_dup || full_w) && ((occ_q != '0) || push)) begin
                        state_d = ST_DUP;
                    end
                end
                ST_DUP: begin
                    if (slot_free) begin
                        pop         = 1'b1;
                        instr_out_d = dup_remap(mem_q[rd_ptr_q]);
                        instr_vld_d = 1'b1;
                        is_dup_d    = 1'b1;
                        if (occ_q == (AW+1)'(1)) begin
                            state_d = ST_ORIG;
                        end
                    end
                end
                default: state_d = ST_ORIG;
            endcase

            if (push) begin
                mem_d[wr_ptr_q] = ifu_instr;
                wr_ptr_d        = wr_ptr_q + AW'(1);
                occ_d           = occ_q + (AW+1)'(1);
                if (orig_cnt_q != CNT_MAX) begin
                    orig_cnt_d = orig_cnt_q + CNT_W'(1);
                end
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                occ_d    = occ_q - (AW+1)'(1);
                if (dup_cnt_q != CNT_MAX) begin
                    dup_cnt_d = dup_cnt_q + CNT_W'(1);
                end
            end

            // Sticky: once a count has saturated the two can no longer be
            // compared meaningfully, so the check point is suppressed.
            sat_d = sat_q || (orig_cnt_d == CNT_MAX) || (dup_cnt_d == CNT_MAX);

            qed_ready_d = (state_q == ST_ORIG) && (occ_q == '0) &&
                          (orig_cnt_q == dup_cnt_q) && (orig_cnt_q != '0) &&
                          !sat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ORIG;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            instr_out_q <= '0;
            instr_vld_q <= 1'b0;
            is_dup_q    <= 1'b0;
            qed_ready_q <= 1'b0;
            orig_cnt_q  <= '0;
            dup_cnt_q   <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            mem_q       <= mem_d;
            instr_out_q <= instr_out_d;
            instr_vld_q <= instr_vld_d;
            is_dup_q    <= is_dup_d;
            qed_ready_q <= qed_ready_d;
            orig_cnt_q  <= orig_cnt_d;
            dup_cnt_q   <= dup_cnt_d;
            sat_q       <= sat_d;
        end
    end

    assign instr_out = instr_out_q;
    assign instr_vld = instr_vld_q;
    assign is_dup    = is_dup_q;
    assign qed_ready = qed_ready_q;
    assign orig_cnt  = orig_cnt_q;
    assign dup_cnt   = dup_cnt_q;
    assign q_full    = full_w;
    assign q_empty   = (occ_q == '0);

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// -----------------------------------------------------------------------------
// tb_qed_dup_scheduler
//
// Directed scenarios plus randomized traffic. A negedge monitor keeps a
// transaction-level model: accepted instructions are appended to an expected
// output stream; when a replay is triggered the recorded originals are
// appended as remapped duplicates. Every output transfer pops and compares.
// -----------------------------------------------------------------------------
module tb_qed_dup_scheduler;

    localparam int         DEPTH = 16;
    localparam logic [6:0] NOP_OPC = 7'b1111111;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        exec_dup;
    logic [31:0] ifu_instr;
    logic        ifu_valid;
    logic        ifu_ready;
    logic        core_ready;
    logic [31:0] instr_out;
    logic        instr_vld;
    logic        is_dup;
    logic        qed_ready;
    logic [7:0]  orig_cnt;
    logic [7:0]  dup_cnt;
    logic        q_full;
    logic        q_empty;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Model state
    logic [32:0] exp_q[$];   // {is_dup, instr} in expected output order
    logic [31:0] mq[$];      // originals awaiting duplication
    int          orig_m;
    int          dup_m;
    int          dup_pend;
    logic        prev_idle, prev_qr_exp, prev_hold, prev_frz;
    logic [31:0] prev_out;
    logic        prev_dup, prev_vld, prev_qr;
    logic        full_pre;
    logic [32:0] exp_e;

    qed_dup_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .exec_dup   (exec_dup),
        .ifu_instr  (ifu_instr),
        .ifu_valid  (ifu_valid),
        .ifu_ready  (ifu_ready),
        .core_ready (core_ready),
        .instr_out  (instr_out),
        .instr_vld  (instr_vld),
        .is_dup     (is_dup),
        .qed_ready  (qed_ready),
        .orig_cnt   (orig_cnt),
        .dup_cnt    (dup_cnt),
        .q_full     (q_full),
        .q_empty    (q_empty)
    );

    // ---------------- clock / reset block ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst        = 1'b1;
        ena        = 1'b0;
        exec_dup   = 1'b0;
        ifu_instr  = '0;
        ifu_valid  = 1'b0;
        core_ready = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Register n (1..15) of the lower bank maps to n+16; x0 is kept.
    function automatic logic [4:0] reg_m(input logic [4:0] n);
        int v;
        v = n;
        if (v != 0) v = 16 + (v % 16);
        return v[4:0];
    endfunction

    function automatic logic [31:0] remap_m(input logic [31:0] i);
        logic [31:0] r;
        logic has_rd, has_rs1, has_rs2, mem;
        has_rd  = (i[6:0] == 7'b0110011) || (i[6:0] == 7'b0010011) || (i[6:0] == 7'b0000011);
        has_rs1 = has_rd || (i[6:0] == 7'b0100011);
        has_rs2 = (i[6:0] == 7'b0110011) || (i[6:0] == 7'b0100011);
        mem     = (i[6:0] == 7'b0000011) || (i[6:0] == 7'b0100011);
        r = i;
        if (has_rd)  r[11:7]  = reg_m(i[11:7]);
        if (has_rs1) r[19:15] = reg_m(i[19:15]);
        if (has_rs2) r[24:20] = reg_m(i[24:20]);
`ifdef QED_MEM_REMAP_EN
        if (mem) r[30] = 1'b1;
`else
        if (mem) r[30] = i[30];
`endif
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [24:0] upper;
        rd    = 5'($urandom_range(0, 15));
        rs1   = 5'($urandom_range(0, 15));
        rs2   = 5'($urandom_range(0, 15));
        imm   = 12'($urandom);
        upper = 25'($urandom);
        case ($urandom_range(0, 5))
            0: return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
            1: return {imm, rs1, 3'b000, rd, 7'b0010011};
            2: return {imm, rs1, 3'b010, rd, 7'b0000011};
            3: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            4: return {upper, NOP_OPC};
            default: return {upper, 7'b0110111};
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mq.delete();
            orig_m    = 0;
            dup_m     = 0;
            dup_pend  = 0;
            prev_idle = 1'b0;
            prev_hold = 1'b0;
            prev_frz  = 1'b0;
        end else begin
            chk("orig_cnt", orig_cnt, orig_m);
            if (exp_q.size() == 0) chk("dup_cnt", dup_cnt, dup_m);
            if (dup_pend == 0) begin
                chk("q_full", q_full, mq.size() == DEPTH);
                chk("q_empty", q_empty, mq.size() == 0);
            end
            if (prev_idle) chk("qed_ready", qed_ready, prev_qr_exp);
            if (prev_hold) begin
                chk("hold_instr_out", instr_out, prev_out);
                chk("hold_is_dup", is_dup, prev_dup);
                chk("hold_instr_vld", instr_vld, prev_vld);
            end
            if (prev_frz) chk("hold_qed_ready", qed_ready, prev_qr);

            prev_qr_exp = (orig_m == dup_m) && (orig_m != 0);
            prev_idle   = ena && (exp_q.size() == 0) && (mq.size() == 0);
            prev_hold   = !ena || (instr_vld && !core_ready);
            prev_frz    = !ena;
            prev_out    = instr_out;
            prev_dup    = is_dup;
            prev_vld    = instr_vld;
            prev_qr     = qed_ready;

            if (ena && core_ready && instr_vld) begin
                if (exp_q.size() == 0) begin
                    chk("instr_vld_unexpected", instr_vld, 1'b0);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("instr_out", {is_dup, instr_out}, exp_e);
                    if (exp_e[32]) begin
                        dup_m++;
                        dup_pend--;
                    end
                end
            end

            full_pre = (mq.size() == DEPTH);
            if (ifu_valid && ifu_ready) begin
                exp_q.push_back({1'b0, ifu_instr});
                if (ifu_instr[6:0] != NOP_OPC) begin
                    mq.push_back(ifu_instr);
                    orig_m++;
                end
            end
            if (ena && (exec_dup || full_pre) && mq.size() != 0) begin
                foreach (mq[i]) begin
                    exp_q.push_back({1'b1, remap_m(mq[i])});
                    dup_pend++;
                end
                mq.delete();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] ins, input logic ex,
                         input logic cr, input logic en, input logic r);
        @(posedge clk);
        #2;
        ifu_valid  = v;
        ifu_instr  = ins;
        exec_dup   = ex;
        core_ready = cr;
        ena        = en;
        rst        = r;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (k < 200 && (exp_q.size() != 0 || mq.size() != 0)) begin
            drive(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
            k++;
        end
        chk("drain_outstanding", exp_q.size() + mq.size(), 0);
        idle(3);
    endtask

    task automatic single_dup(input logic [31:0] ins, input logic [31:0] exp_dup, input logic qed_exp);
        drive(1'b1, ins, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);
        #1;
        chk("single_orig_out", instr_out, ins);
        chk("single_orig_is_dup", is_dup, 1'b0);
        idle(1);
        #1;
        chk("single_dup_out", instr_out, exp_dup);
        chk("single_dup_is_dup", is_dup, 1'b1);
        chk("single_qed_latency", qed_ready, 1'b0);
        idle(1);
        #1;
        chk("single_qed_ready", qed_ready, qed_exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a, b, c;

        // Reset state
        do_reset();
        #1;
        chk("rst_instr_vld", instr_vld, 1'b0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_is_dup", is_dup, 1'b0);
        chk("rst_qed_ready", qed_ready, 1'b0);
        chk("rst_q_empty", q_empty, 1'b1);
        chk("rst_q_full", q_full, 1'b0);
        chk("rst_orig_cnt", orig_cnt, 8'd0);
        chk("rst_dup_cnt", dup_cnt, 8'd0);

        // ADDI x1,x2,5 -> x17,x18 ; ADD x3,x1,x0 -> x19,x17,x0
        single_dup(32'h00510093, 32'h00590893, 1'b1);
        chk("t1_orig_cnt", orig_cnt, 8'd1);
        chk("t1_dup_cnt", dup_cnt, 8'd1);
        single_dup(32'h000081B3, 32'h000889B3, 1'b1);

        // NOP with exec_dup: issued, not counted, never replayed
        drive(1'b1, 32'h0000007F, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);
        #1;
        chk("nop_out", instr_out, 32'h0000007F);
        chk("nop_is_dup", is_dup, 1'b0);
        chk("nop_orig_cnt", orig_cnt, 8'd2);
        idle(1);
        #1;
        chk("nop_no_dup_vld", instr_vld, 1'b0);

        // Stall during replay: output and dup_cnt hold for three cycles
        a = 32'h00510093;
        b = 32'h00208133;
        c = 32'h0041A223;
        drive(1'b1, a, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, b, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, c, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            chk("stall_out", instr_out, remap_m(a));
            chk("stall_is_dup", is_dup, 1'b1);
            chk("stall_dup_cnt", dup_cnt, 8'd3);
        end
        drain();
        chk("stall_orig_cnt", orig_cnt, 8'd5);
        chk("stall_dup_cnt_end", dup_cnt, 8'd5);

        // Fill the queue without exec_dup: forced replay
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, {12'(i + 1), 5'd2, 3'b000, 5'(1 + i % 15), 7'b0010011},
                  1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'h00510093, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("full_q_full", q_full, 1'b1);
        chk("full_ifu_ready", ifu_ready, 1'b0);
        drain();
        chk("full_orig_cnt", orig_cnt, 8'd16);
        chk("full_dup_cnt", dup_cnt, 8'd16);
        chk("full_q_empty_end", q_empty, 1'b1);
        chk("full_qed_ready", qed_ready, 1'b1);

        // Reset in the middle of a replay; load remap
        do_reset();
        drive(1'b1, 32'h00402083, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'h00812103, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'h00C1A183, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 32'h01022203, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);
        #1;
        chk("mid_last_orig", instr_out, 32'h01022203);
        idle(1);
        #1;
`ifdef QED_MEM_REMAP_EN
        chk("lw_dup", instr_out, 32'h40402883);
`else
        chk("lw_dup", instr_out, 32'h00402883);
`endif
        chk("lw_dup_is_dup", is_dup, 1'b1);
        chk("mid_dup_cnt1", dup_cnt, 8'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("mid_dup_cnt2", dup_cnt, 8'd2);
        idle(1);
        #1;
        chk("mid_rst_instr_vld", instr_vld, 1'b0);
        chk("mid_rst_q_empty", q_empty, 1'b1);
        chk("mid_rst_orig_cnt", orig_cnt, 8'd0);
        chk("mid_rst_dup_cnt", dup_cnt, 8'd0);
        chk("mid_rst_qed", qed_ready, 1'b0);
        idle(2);
        #1;
        chk("mid_rst_no_replay", instr_vld, 1'b0);

        // Randomized windows
        for (int w = 0; w < 4; w++) begin
            do_reset();
            for (int c2 = 0; c2 < 200; c2++) begin
                drive($urandom_range(0, 3) != 0, rand_instr(),
                      $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0);
            end
            drain();
        end

        chk("final_exp_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
